// File: rtl/mips_cpu_hilo_pkg.sv
// rtl/mips_cpu_hilo_pkg.sv - op codes, FSM states and iteration count for the HI/LO unit
package mips_cpu_hilo_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam int ITER_N = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mips_cpu_hilo_iter.sv
// rtl/mips_cpu_hilo_iter.sv - one shift-add (multiply) or restoring shift-subtract (divide) step per cycle
module mips_cpu_hilo_iter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [DATA_W-1:0] a_mag,
  input  logic [DATA_W-1:0] b_mag,
  output logic [DATA_W-1:0] upper,
  output logic [DATA_W-1:0] lower
);

  // Multiply: {upper,lower} is the product accumulator, lower initially the multiplier.
  // Divide: upper is the partial remainder, lower shifts dividend out and quotient in.
  logic [DATA_W-1:0] operand;
  logic [DATA_W:0]   add_sum;
  logic [DATA_W:0]   shifted;
  logic [DATA_W-1:0] diff;
  logic              ge;

  always_comb begin
    add_sum = {1'b0, upper} + (lower[0] ? {1'b0, operand} : {(DATA_W+1){1'b0}});
    shifted = {upper, lower[DATA_W-1]};
    ge      = shifted >= {1'b0, operand};
    diff    = shifted[DATA_W-1:0] - operand;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      upper   <= '0;
      lower   <= '0;
      operand <= '0;
    end else if (load) begin
      upper   <= '0;
      lower   <= a_mag;
      operand <= b_mag;
    end else if (step) begin
      if (is_div) begin
        upper <= ge ? diff : shifted[DATA_W-1:0];
        lower <= {lower[DATA_W-2:0], ge};
      end else begin
        upper <= add_sum[DATA_W:1];
        lower <= {add_sum[0], lower[DATA_W-1:1]};
      end
    end
  end

endmodule

// File: rtl/mips_cpu_hilo_unit.sv
// rtl/mips_cpu_hilo_unit.sv - HI/LO owner: iterative MULT/MULTU/DIV/DIVU, MTHI/MTLO; HILO_FAST_MULT_EN selects single-cycle multiply
module mips_cpu_hilo_unit
  import mips_cpu_hilo_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ITER_CNT_W = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  state_t                  state;
  logic [ITER_CNT_W-1:0]   counter;
  logic                    is_div_q;
  logic                    neg_lo_q;
  logic                    neg_hi_q;
  logic                    zero_q;
  logic [DATA_W-1:0]       a_q;

  logic                    is_signed;
  logic                    is_div;
  logic                    load;
  logic [DATA_W-1:0]       a_mag;
  logic [DATA_W-1:0]       b_mag;
  logic [DATA_W-1:0]       upper;
  logic [DATA_W-1:0]       lower;
  logic [DATA_W-1:0]       quo;
  logic [DATA_W-1:0]       rem;
  logic [2*DATA_W-1:0]     prod;

  always_comb begin
    is_signed = op_is_signed(op);
    is_div    = op_is_div(op);
`ifdef HILO_FAST_MULT_EN
    load      = (state == IDLE) && start && is_div;
`else
    load      = (state == IDLE) && start && (is_div || op == OP_MULT || op == OP_MULTU);
`endif
    // Negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude.
    a_mag     = (is_signed && a[DATA_W-1]) ? -a : a;
    b_mag     = (is_signed && b[DATA_W-1]) ? -b : b;
    prod      = neg_lo_q ? -{upper, lower} : {upper, lower};
    quo       = neg_lo_q ? -lower : lower;
    rem       = neg_hi_q ? -upper : upper;
  end

`ifdef HILO_FAST_MULT_EN
  logic [2*DATA_W-1:0] fast_prod;
  always_comb begin
    fast_prod = {{DATA_W{is_signed & a[DATA_W-1]}}, a} * {{DATA_W{is_signed & b[DATA_W-1]}}, b};
  end
`endif

  mips_cpu_hilo_iter #(.DATA_W(DATA_W)) u_iter (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .step    (state == RUN),
    .is_div  (is_div_q),
    .a_mag   (a_mag),
    .b_mag   (b_mag),
    .upper   (upper),
    .lower   (lower)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      counter  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      zero_q   <= 1'b0;
      a_q      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            state    <= RUN;
            busy     <= 1'b1;
            counter  <= '0;
            is_div_q <= is_div;
            neg_lo_q <= is_signed & (a[DATA_W-1] ^ b[DATA_W-1]);
            // Remainder follows the dividend; a product's high half follows the product.
            neg_hi_q <= is_signed & (is_div ? a[DATA_W-1] : (a[DATA_W-1] ^ b[DATA_W-1]));
            zero_q   <= (b == '0);
            a_q      <= a;
          end else if (start) begin
            case (op)
              OP_MTHI: begin
                hi   <= a;
                done <= 1'b1;
              end
              OP_MTLO: begin
                lo   <= a;
                done <= 1'b1;
              end
`ifdef HILO_FAST_MULT_EN
              OP_MULT, OP_MULTU: begin
                hi   <= fast_prod[2*DATA_W-1:DATA_W];
                lo   <= fast_prod[DATA_W-1:0];
                done <= 1'b1;
              end
`endif
              default: ;
            endcase
          end
        end
        RUN: begin
          counter <= counter + 1'b1;
          if (counter == ITER_CNT_W'(ITER_N - 1)) state <= FIX;
        end
        FIX: begin
          if (is_div_q) begin
            if (zero_q) begin
              lo <= '1;
              hi <= a_q;
            end else begin
              lo <= quo;
              hi <= rem;
            end
            div_zero <= zero_q;
          end else begin
            hi <= prod[2*DATA_W-1:DATA_W];
            lo <= prod[DATA_W-1:0];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_hilo_unit.sv
// tb/tb_mips_cpu_hilo_unit.sv - randomized bench with a latency/arithmetic reference model and directed literal checks
module tb_mips_cpu_hilo_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  mips_cpu_hilo_unit dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  // Reference model: an accepted mult/div lands its result 33 edges after issue.
  logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
  logic        m_busy = 0, m_done = 0, m_dz = 0, p_dz = 0, p_div = 0;
  int          m_left = 0;

  task automatic model_issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sq, sr;
    logic [63:0] up;
    case (o)
      3'd0: begin
        sq = longint'($signed(x)) * longint'($signed(y));
        p_hi = sq[63:32]; p_lo = sq[31:0]; p_div = 0;
      end
      3'd1: begin
        up = {32'd0, x} * {32'd0, y};
        p_hi = up[63:32]; p_lo = up[31:0]; p_div = 0;
      end
      3'd2, 3'd3: begin
        p_div = 1;
        p_dz  = (y == 0);
        if (y == 0) begin
          p_lo = 32'hFFFF_FFFF; p_hi = x;
        end else if (o == 3'd2) begin
          sq = longint'($signed(x)) / longint'($signed(y));
          sr = longint'($signed(x)) % longint'($signed(y));
          p_lo = sq[31:0]; p_hi = sr[31:0];
        end else begin
          p_lo = x / y; p_hi = x % y;
        end
      end
      3'd4: begin m_hi = x; m_done = 1; end
      3'd5: begin m_lo = x; m_done = 1; end
      default: ;
    endcase
    if (o <= 3'd3) begin
      m_busy = 1;
      m_left = 33;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_hi = 0; m_lo = 0; m_busy = 0; m_done = 0; m_dz = 0; m_left = 0;
      end else begin
        m_done = 0;
        if (m_left > 0) begin
          m_left--;
          if (m_left == 0) begin
            m_hi = p_hi; m_lo = p_lo; m_busy = 0; m_done = 1;
            if (p_div) m_dz = p_dz;
          end
        end else if (start) begin
          model_issue(op, a, b);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        checks++;
        if ({hi, lo, busy, done, div_zero} !== {m_hi, m_lo, m_busy, m_done, m_dz}) begin
          errors++;
          $display("FAIL cycle_compare t=%0t dut hi=%h lo=%h busy=%b done=%b dz=%b model hi=%h lo=%h busy=%b done=%b dz=%b",
                   $time, hi, lo, busy, done, div_zero, m_hi, m_lo, m_busy, m_done, m_dz);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int bcnt, output int dcnt);
    @(negedge clk);
    start = 1; op = o; a = x; b = y;
    @(negedge clk);
    start = 0;
    bcnt = 0; dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) bcnt++;
      if (done) dcnt++;
      @(negedge clk);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  int bc, dc;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_flags", {29'd0, busy, done, div_zero}, 32'd0);
    reset_n = 1;

    run_op(3'd0, 32'hFFFF_FFFD, 32'd5, bc, dc);
    chk("mult_neg_hi", hi, 32'hFFFF_FFFF);
    chk("mult_neg_lo", lo, 32'hFFFF_FFF1);
    chk("mult_busy_cycles", 32'(bc), 32'd33);
    chk("mult_done_pulses", 32'(dc), 32'd1);

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, dc);
    chk("multu_max_hi", hi, 32'hFFFF_FFFE);
    chk("multu_max_lo", lo, 32'h0000_0001);

    run_op(3'd3, 32'd100, 32'd7, bc, dc);
    chk("divu_lo", lo, 32'h0000_000E);
    chk("divu_hi", hi, 32'h0000_0002);

    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, bc, dc);
    chk("div_neg_lo", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi, 32'hFFFF_FFFF);

    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, bc, dc);
    chk("div_min_lo", lo, 32'h8000_0000);
    chk("div_min_hi", hi, 32'h0000_0000);

    run_op(3'd2, 32'h0000_1234, 32'd0, bc, dc);
    chk("div0_lo", lo, 32'hFFFF_FFFF);
    chk("div0_hi", hi, 32'h0000_1234);
    chk("div0_flag", {31'd0, div_zero}, 32'd1);
    chk("div0_busy_cycles", 32'(bc), 32'd33);

    run_op(3'd3, 32'd9, 32'd3, bc, dc);
    chk("divu_clear_lo", lo, 32'd3);
    chk("divu_clear_hi", hi, 32'd0);
    chk("divu_clear_flag", {31'd0, div_zero}, 32'd0);

    // MTHI issued mid-divide must be dropped.
    @(negedge clk);
    start = 1; op = 3'd3; a = 32'd50; b = 32'd5;
    @(negedge clk);
    start = 0;
    repeat (5) @(negedge clk);
    start = 1; op = 3'd4; a = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 0;
    repeat (40) @(negedge clk);
    chk("mthi_busy_ignored_hi", hi, 32'd0);
    chk("mthi_busy_ignored_lo", lo, 32'd10);

    run_op(3'd4, 32'hDEAD_BEEF, 32'd0, bc, dc);
    chk("mthi_hi", hi, 32'hDEAD_BEEF);
    chk("mthi_lo_kept", lo, 32'd10);
    chk("mthi_no_busy", 32'(bc), 32'd0);
    chk("mthi_done", 32'(dc), 32'd1);

    run_op(3'd5, 32'h0BAD_F00D, 32'd0, bc, dc);
    chk("mtlo_lo", lo, 32'h0BAD_F00D);
    chk("mtlo_hi_kept", hi, 32'hDEAD_BEEF);

    run_op(3'd6, 32'd1, 32'd2, bc, dc);
    chk("unknown_op_hi", hi, 32'hDEAD_BEEF);
    chk("unknown_op_done", 32'(dc + bc), 32'd0);

    // Reset ten cycles into a divide.
    @(negedge clk);
    start = 1; op = 3'd2; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 0;
    repeat (10) @(negedge clk);
    #2 reset_n = 0;
    #1;
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset_n = 1;

    run_op(3'd1, 32'd6, 32'd7, bc, dc);
    chk("post_reset_lo", lo, 32'd42);
    chk("post_reset_hi", hi, 32'd0);

    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      op    = 3'($urandom_range(0, 7));
      a     = pick();
      b     = pick();
    end
    @(negedge clk);
    start = 0;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_cpu_hilo_unit.md
Name: mips_cpu_hilo_unit

Overview:
Multi-cycle multiply/divide unit that owns the architectural HI/LO registers for MULT, MULTU, DIV, DIVU, MTHI and MTLO. It sits directly downstream of the ALU operand path: it takes the same rs/rt operand values and returns hi/lo to the ALU result mux for MFHI/MFLO. It replaces combinational HI/LO arithmetic with a 32-iteration shift-add / restoring-divide datapath plus a busy/done handshake that stalls the pipeline.

Parameters:
DATA_W, 32, operand and HI/LO width; only 32 is supported.
ITER_CNT_W, 6, width of the iteration counter; must hold DATA_W.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
start  input  1  issue pulse, sampled on the rising edge
op  input  3  operation code (package constants)
a  input  DATA_W  rs operand; dividend or multiplicand
b  input  DATA_W  rt operand; divisor or multiplier
busy  output  1  iterative op in flight; CPU stalls any HI/LO access
done  output  1  one-cycle pulse after HI/LO is written
div_zero  output  1  sticky flag: last DIV/DIVU had b==0
hi  output  DATA_W  architectural HI register
lo  output  DATA_W  architectural LO register

Behaviour:
- Reset (async, reset_n=0): hi=0, lo=0, busy=0, done=0, div_zero=0, state=IDLE, counter=0. Reset mid-operation aborts the op; the partial result is discarded.
- FSM states: IDLE, RUN, FIX.
- IDLE + start + op=MTHI: hi<=a at the same edge; done=1 next cycle; no busy.
- IDLE + start + op=MTLO: lo<=a at the same edge; done=1 next cycle; no busy.
- IDLE + start + mult/div op: latch operand magnitudes and result signs (signed ops only); counter<=0; go to RUN; busy=1.
- RUN: one iteration per cycle for 32 cycles.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract producing a 32-bit quotient and remainder.
  - After counter==31, go to FIX.
- FIX: apply two's-complement sign correction, write hi/lo, pulse done, go to IDLE with busy=0.
- Latency: start on edge E0; hi/lo valid and busy=0 after edge E33; done high for the cycle following E33.
- Signed rules:
  - Product sign = a[31]^b[31].
  - Quotient truncates toward zero.
  - Remainder takes the dividend's sign.
  - Operand 0x80000000 uses an unsigned magnitude of 0x80000000, with no overflow.
- Divide by zero, b==0 for DIV or DIVU: completes with normal latency; lo=0xFFFFFFFF, hi=a; div_zero<=1. Any later completed DIV/DIVU with b!=0 clears div_zero.
- start while busy (any op, including MTHI/MTLO): ignored. There is no queueing and no error output.
- Unknown op code with start: ignored; state unchanged.
- hi/lo hold their values except on the writes defined above; they are readable at all times.

Optional Feature:
HILO_FAST_MULT_EN.
- Defined: MULT and MULTU use a single-cycle 64-bit multiplier. hi/lo are written at the start edge E0, done pulses the next cycle, and busy never asserts for multiplies. Divides are unchanged.
- Undefined: multiplies use the 33-cycle iterative path described above.

Decomposition:
- Package mips_cpu_hilo_pkg:
  - op constants: OP_MULT=0, OP_MULTU=1, OP_DIV=2, OP_DIVU=3, OP_MTHI=4, OP_MTLO=5.
  - FSM state enum.
  - Iteration count constant of 32.
- Sub-module mips_cpu_hilo_iter: holds the accumulator and partial-remainder registers and performs one shift-add or shift-subtract step per cycle. The top level keeps the FSM, sign handling and the HI/LO registers.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 -> after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFF1; done pulses once; busy high for exactly 33 cycles.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. DIVU a=100, b=7 -> lo=0x0000000E, hi=0x00000002.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x00001234, div_zero=1. Then DIVU 9/3 -> lo=3, hi=0, div_zero=0.
- MTHI a=0xDEADBEEF issued while busy is ignored; issued in IDLE -> hi=0xDEADBEEF one edge later with no busy; lo unchanged.
- Assert reset_n=0 at RUN cycle 10 of a DIV -> hi=lo=0 and busy=0 immediately. After release, MULTU 6*7 -> lo=42, hi=0.
